// File: rtl/veripong_pkg.sv
// veripong_pkg: constants and types shared by the veripong pixel datapath.
//   WIDTH/HEIGHT        : frame size in pixels
//   X_W/Y_W/COLOUR_W    : coordinate and colour widths on the plot stream
//   BACKGROUND          : colour that leaves a pixel empty
//   state_t             : shadow_probe controller states
//   pix_addr()          : linear framebuffer address y*width + x
package veripong_pkg;

    localparam int WIDTH    = 32'd320;
    localparam int HEIGHT   = 32'd240;
    localparam int X_W      = 32'd9;
    localparam int Y_W      = 32'd8;
    localparam int COLOUR_W = 32'd3;

    localparam logic [COLOUR_W-1:0] BACKGROUND = 3'b000;

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_IDLE  = 2'd1,
        S_READ  = 2'd2,
        S_RSP   = 2'd3
    } state_t;

    // Both coordinates are zero-extended to 32 bits before the multiply, so
    // the product never wraps for any frame that fits the coordinate widths.
    function automatic logic [31:0] pix_addr(
        input logic [X_W-1:0] x,
        input logic [Y_W-1:0] y,
        input logic [31:0]    width
    );
        logic [31:0] x_s;
        logic [31:0] y_s;
        x_s = {{(32 - X_W){1'b0}}, x};
        y_s = {{(32 - Y_W){1'b0}}, y};
        return (y_s * width) + x_s;
    endfunction

endpackage

// File: rtl/shadow_probe_if.sv
// shadow_probe_if: plot-stream snoop plus occupancy query/response bundle.
//   plot/X/Y/color : pixel write stream (same signals as the VGA adapter sees)
//   clear          : one-cycle pulse starting a full-frame wipe
//   q_valid/q_x/q_y/q_ready : query request handshake
//   r_valid/r_hit  : one-cycle response strobe and held hit flag
//   busy           : wipe in progress
// master = game logic / plotter side, slave = shadow_probe.
interface shadow_probe_if;
    import veripong_pkg::*;

    logic                plot;
    logic [X_W-1:0]      X;
    logic [Y_W-1:0]      Y;
    logic [COLOUR_W-1:0] color;
    logic                clear;
    logic                q_valid;
    logic [X_W-1:0]      q_x;
    logic [Y_W-1:0]      q_y;
    logic                q_ready;
    logic                r_valid;
    logic                r_hit;
    logic                busy;

    modport master (
        output plot, X, Y, color, clear, q_valid, q_x, q_y,
        input  q_ready, r_valid, r_hit, busy
    );

    modport slave (
        input  plot, X, Y, color, clear, q_valid, q_x, q_y,
        output q_ready, r_valid, r_hit, busy
    );

endinterface

// File: rtl/shadow_ram.sv
// shadow_ram: 1-bit simple dual-port RAM holding the occupancy shadow.
//   clk          : clock
//   rst          : clears only the read data register, never the array
//   we/waddr/wdata : synchronous write port
//   re/raddr/rdata : synchronous read port; rdata holds between reads
// A same-edge read and write at one address returns the old contents.
module shadow_ram #(
    parameter int DEPTH  = 32'd76800,
    parameter int ADDR_W = 32'd17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic              wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic              rdata
);

    logic mem_r [0:DEPTH-1];

    // Write port; the array has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Read port; non-blocking update makes a colliding write invisible here.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= 1'b0;
        end else if (re) begin
            rdata <= mem_r[raddr];
        end
    end

endmodule

// File: rtl/shadow_probe.sv
// shadow_probe: occupancy shadow of the plotted frame with a query port.
//   clk : clock
//   rst : synchronous active-high reset (starts a wipe)
//   bus : shadow_probe_if.slave - plot snoop, clear, query and response
// The controller wipes the shadow after reset/clear, then serves one query
// per three cycles: IDLE (accept) -> READ (RAM read) -> RSP (r_valid).
module shadow_probe #(
    parameter int WIDTH    = veripong_pkg::WIDTH,
    parameter int HEIGHT   = veripong_pkg::HEIGHT,
    parameter int X_W      = veripong_pkg::X_W,
    parameter int Y_W      = veripong_pkg::Y_W,
    parameter int COLOUR_W = veripong_pkg::COLOUR_W,
    parameter logic [COLOUR_W-1:0] BACKGROUND = veripong_pkg::BACKGROUND
) (
    input logic           clk,
    input logic           rst,
    shadow_probe_if.slave bus
);
    import veripong_pkg::*;

    localparam int DEPTH  = WIDTH * HEIGHT;
    localparam int ADDR_W = $clog2(DEPTH);

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
    localparam logic [X_W:0]      WIDTH_LIM  = (X_W + 1)'(WIDTH);
    localparam logic [Y_W:0]      HEIGHT_LIM = (Y_W + 1)'(HEIGHT);

    // One extra bit on each side keeps the compare exact even when the
    // frame dimension equals 2**width.
    function automatic logic in_frame(
        input logic [X_W-1:0] x,
        input logic [Y_W-1:0] y
    );
        return ({1'b0, x} < WIDTH_LIM) && ({1'b0, y} < HEIGHT_LIM);
    endfunction

    logic                plot_s;
    logic [X_W-1:0]      wx_s;
    logic [Y_W-1:0]      wy_s;
    logic [COLOUR_W-1:0] color_s;
    logic                clear_s;
    logic                q_valid_s;
    logic [X_W-1:0]      q_x_s;
    logic [Y_W-1:0]      q_y_s;

    assign plot_s    = bus.plot;
    assign wx_s      = bus.X;
    assign wy_s      = bus.Y;
    assign color_s   = bus.color;
    assign clear_s   = bus.clear;
    assign q_valid_s = bus.q_valid;
    assign q_x_s     = bus.q_x;
    assign q_y_s     = bus.q_y;

    state_t              state_r;
    state_t              state_next_s;
    logic [ADDR_W-1:0]   sweep_r;
    logic [X_W-1:0]      qx_r;
    logic [Y_W-1:0]      qy_r;
    logic                oor_r;
    logic                busy_r;
    logic                q_ready_r;
    logic                r_valid_r;
    logic                busy_s;
    logic                q_ready_s;
    logic                r_valid_s;
    logic                accept_s;
    logic                abort_s;

    logic                we_s;
    logic [ADDR_W-1:0]   waddr_s;
    logic                wdata_s;
    logic                re_s;
    logic [ADDR_W-1:0]   raddr_s;
    logic                rdata_s;

    // Reset or clear cancels whatever the controller is doing this cycle.
    assign abort_s  = rst || clear_s;
    assign accept_s = (state_r == S_IDLE) && q_valid_s && q_ready_r && !abort_s;

    // Controller state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_CLEAR;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode; reset and clear both force a fresh wipe.
    always_comb begin
        state_next_s = state_r;
        if (abort_s) begin
            state_next_s = S_CLEAR;
        end else begin
            case (state_r)
                S_CLEAR: begin
                    if (sweep_r == LAST_ADDR) begin
                        state_next_s = S_IDLE;
                    end else begin
                        state_next_s = S_CLEAR;
                    end
                end
                S_IDLE: begin
                    if (q_valid_s && q_ready_r) begin
                        state_next_s = S_READ;
                    end else begin
                        state_next_s = S_IDLE;
                    end
                end
                S_READ:  state_next_s = S_RSP;
                S_RSP:   state_next_s = S_IDLE;
                default: state_next_s = S_CLEAR;
            endcase
        end
    end

    // Status outputs decoded from the upcoming state so they can be registered
    // without lagging the state itself.
    always_comb begin
        busy_s    = 1'b0;
        q_ready_s = 1'b0;
        r_valid_s = 1'b0;
        case (state_next_s)
            S_CLEAR: busy_s    = 1'b1;
            S_IDLE:  q_ready_s = 1'b1;
            S_READ:  q_ready_s = 1'b0;
            S_RSP:   r_valid_s = 1'b1;
            default: busy_s    = 1'b1;
        endcase
    end

    // Status output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r    <= 1'b1;
            q_ready_r <= 1'b0;
            r_valid_r <= 1'b0;
        end else begin
            busy_r    <= busy_s;
            q_ready_r <= q_ready_s;
            r_valid_r <= r_valid_s;
        end
    end

    // Wipe address counter; restarts from zero on every reset or clear.
    always_ff @(posedge clk) begin
        if (abort_s) begin
            sweep_r <= {ADDR_W{1'b0}};
        end else if (state_r == S_CLEAR) begin
            if (sweep_r == LAST_ADDR) begin
                sweep_r <= {ADDR_W{1'b0}};
            end else begin
                sweep_r <= sweep_r + {{(ADDR_W - 1){1'b0}}, 1'b1};
            end
        end
    end

    // Query coordinate latch and out-of-frame flag for the response.
    always_ff @(posedge clk) begin
        if (rst) begin
            qx_r  <= {X_W{1'b0}};
            qy_r  <= {Y_W{1'b0}};
            oor_r <= 1'b0;
        end else begin
            if (accept_s) begin
                qx_r <= q_x_s;
                qy_r <= q_y_s;
            end
            if ((state_r == S_READ) && !clear_s) begin
                oor_r <= !in_frame(qx_r, qy_r);
            end
        end
    end

    // Write mux: the wipe owns the port while clearing, plots otherwise.
    always_comb begin
        if (state_r == S_CLEAR) begin
            we_s    = 1'b1;
            waddr_s = sweep_r;
            wdata_s = 1'b0;
        end else begin
            we_s    = plot_s && in_frame(wx_s, wy_s) && !abort_s;
            waddr_s = ADDR_W'(pix_addr(wx_s, wy_s, WIDTH));
            wdata_s = (color_s != BACKGROUND);
        end
    end

    // Read is skipped for out-of-frame queries so the RAM never sees an
    // address past the last pixel.
    always_comb begin
        re_s    = (state_r == S_READ) && !abort_s && in_frame(qx_r, qy_r);
        raddr_s = ADDR_W'(pix_addr(qx_r, qy_r, WIDTH));
    end

    shadow_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (we_s),
        .waddr (waddr_s),
        .wdata (wdata_s),
        .re    (re_s),
        .raddr (raddr_s),
        .rdata (rdata_s)
    );

    // rdata and oor_r only change on a READ edge, so r_hit holds its value
    // from one response to the next.
    assign bus.r_hit   = oor_r | rdata_s;
    assign bus.busy    = busy_r;
    assign bus.q_ready = q_ready_r;
    assign bus.r_valid = r_valid_r;

endmodule

// File: tb/tb_shadow_probe.sv
// tb_shadow_probe: table vectors, hand-written corner sequences and random
// plot/query traffic against an occupancy-array reference model.
// A reduced frame keeps each wipe short.
module tb_shadow_probe;
    import veripong_pkg::*;

    localparam int W   = 32'd64;
    localparam int H   = 32'd48;
    localparam int NPX = W * H;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    bit occ [0:NPX-1];

    shadow_probe_if bus ();

    shadow_probe #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    function automatic logic model_hit(input int x, input int y);
        if (x >= W || y >= H) return 1'b1;
        return occ[y * W + x];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NPX; i++) occ[i] = 1'b0;
    endtask

    task automatic plot_px(input int x, input int y, input int c);
        bus.plot  = 1'b1;
        bus.X     = X_W'(x);
        bus.Y     = Y_W'(y);
        bus.color = COLOUR_W'(c);
        tick();
        bus.plot  = 1'b0;
        if (x < W && y < H) occ[y * W + x] = (c != 0);
    endtask

    task automatic query(input int x, input int y, input logic exp, input string nm);
        int n;
        n = 0;
        while (!bus.q_ready && n < 20) begin
            tick();
            n++;
        end
        chk({nm, "_ready"}, 32'(bus.q_ready), 32'd1);
        bus.q_valid = 1'b1;
        bus.q_x     = X_W'(x);
        bus.q_y     = Y_W'(y);
        tick();
        bus.q_valid = 1'b0;
        chk({nm, "_gap"}, {30'd0, bus.q_ready, bus.r_valid}, 32'd0);
        tick();
        chk({nm, "_rsp"}, {30'd0, bus.r_valid, bus.r_hit}, {30'd0, 1'b1, exp});
        tick();
        chk({nm, "_hold"}, {29'd0, bus.q_ready, bus.r_valid, bus.r_hit},
            {29'd0, 1'b1, 1'b0, exp});
    endtask

    // Counts cycles busy is seen high from now on; r_valid must stay low.
    task automatic wipe_len(output int n, output logic rv_seen);
        n = 0;
        rv_seen = 1'b0;
        while (bus.busy && n < 2 * NPX + 10) begin
            if (bus.r_valid) rv_seen = 1'b1;
            n++;
            tick();
        end
    endtask

    typedef struct {
        logic is_q;
        int   x;
        int   y;
        int   col;
        logic exp;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int   n;
        logic rv;
        logic bad;

        bus.plot = 1'b0; bus.X = '0; bus.Y = '0; bus.color = '0;
        bus.clear = 1'b0; bus.q_valid = 1'b0; bus.q_x = '0; bus.q_y = '0;
        model_clear();

        tbl.push_back('{1'b1, 32'd5,   32'd5,   32'd0, 1'b0});
        tbl.push_back('{1'b0, 32'd10,  32'd20,  32'd7, 1'b0});
        tbl.push_back('{1'b1, 32'd10,  32'd20,  32'd0, 1'b1});
        tbl.push_back('{1'b1, 32'd11,  32'd20,  32'd0, 1'b0});
        tbl.push_back('{1'b0, 32'd10,  32'd20,  32'd0, 1'b0});
        tbl.push_back('{1'b1, 32'd10,  32'd20,  32'd0, 1'b0});
        tbl.push_back('{1'b1, 32'd64,  32'd0,   32'd0, 1'b1});
        tbl.push_back('{1'b1, 32'd0,   32'd48,  32'd0, 1'b1});
        tbl.push_back('{1'b1, 32'd511, 32'd255, 32'd0, 1'b1});
        tbl.push_back('{1'b0, 32'd80,  32'd10,  32'd7, 1'b0});
        tbl.push_back('{1'b1, 32'd16,  32'd10,  32'd0, 1'b0});
        tbl.push_back('{1'b0, 32'd63,  32'd47,  32'd2, 1'b0});
        tbl.push_back('{1'b1, 32'd63,  32'd47,  32'd0, 1'b1});
        tbl.push_back('{1'b1, 32'd0,   32'd0,   32'd0, 1'b0});

        // Reset state and first wipe.
        tick();
        tick();
        chk("reset_outs", {28'd0, bus.q_ready, bus.r_valid, bus.r_hit, bus.busy}, 32'd1);
        rst = 1'b0;
        wipe_len(n, rv);
        chk("reset_wipe_len", 32'(n), 32'(NPX));
        chk("reset_wipe_rv", 32'(rv), 32'd0);
        chk("ready_after_wipe", {30'd0, bus.q_ready, bus.busy}, 32'd2);

        // Table vectors.
        foreach (tbl[i]) begin
            if (tbl[i].is_q) query(tbl[i].x, tbl[i].y, tbl[i].exp, $sformatf("tbl%0d", i));
            else plot_px(tbl[i].x, tbl[i].y, tbl[i].col);
        end

        // Plot landing on the accept edge is visible to that query.
        plot_px(8, 8, 0);
        bus.q_valid = 1'b1; bus.q_x = X_W'(8); bus.q_y = Y_W'(8);
        bus.plot = 1'b1; bus.X = X_W'(8); bus.Y = Y_W'(8); bus.color = 3'd5;
        tick();
        bus.q_valid = 1'b0; bus.plot = 1'b0;
        occ[8 * W + 8] = 1'b1;
        tick();
        chk("acc_edge_write", {30'd0, bus.r_valid, bus.r_hit}, 32'd3);
        tick();

        // Plot landing on the READ edge is not seen (old value returned).
        plot_px(7, 7, 0);
        bus.q_valid = 1'b1; bus.q_x = X_W'(7); bus.q_y = Y_W'(7);
        tick();
        bus.q_valid = 1'b0;
        bus.plot = 1'b1; bus.X = X_W'(7); bus.Y = Y_W'(7); bus.color = 3'd1;
        tick();
        bus.plot = 1'b0;
        occ[7 * W + 7] = 1'b1;
        chk("collide_old", {30'd0, bus.r_valid, bus.r_hit}, 32'd2);
        tick();
        query(7, 7, model_hit(7, 7), "collide_next");

        // Random traffic against the model.
        for (int k = 0; k < 150; k++) begin
            int x, y, c;
            x = $urandom_range(0, W + 7);
            y = $urandom_range(0, H + 3);
            c = $urandom_range(0, 7);
            if ($urandom_range(0, 1) == 0) plot_px(x, y, c);
            else query(x, y, model_hit(x, y), "rnd");
        end

        // Clear abandons an in-flight query, drops plots, and restarts on re-clear.
        plot_px(30, 30, 7);
        query(30, 30, model_hit(30, 30), "pre_clear");
        bus.q_valid = 1'b1; bus.q_x = X_W'(30); bus.q_y = Y_W'(30);
        tick();
        bus.q_valid = 1'b0;
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        model_clear();
        bad = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.r_valid || !bus.busy || bus.q_ready) bad = 1'b1;
            if (i == 50) begin
                bus.plot = 1'b1; bus.X = X_W'(31); bus.Y = Y_W'(31); bus.color = 3'd7;
            end else begin
                bus.plot = 1'b0;
            end
            tick();
        end
        bus.plot = 1'b0;
        chk("clear_abandon", 32'(bad), 32'd0);
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        wipe_len(n, rv);
        chk("reclear_wipe_len", 32'(n), 32'(NPX));
        chk("reclear_wipe_rv", 32'(rv), 32'd0);
        query(30, 30, 1'b0, "post_clear_a");
        query(31, 31, 1'b0, "post_clear_drop");
        query(7, 7, 1'b0, "post_clear_b");
        query(63, 47, 1'b0, "post_clear_c");
        query(64, 5, 1'b1, "post_clear_oor");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shadow_probe.md
# shadow_probe

Read-side counterpart of the pixel plot stream that drives the VGA adapter. It snoops every plot write (x, y, colour, plot) and keeps a 1-bit occupancy shadow of the 320x240 frame. Game logic such as ball/paddle collision queries any pixel through a valid/ready handshake, so it never needs to read back from the adapter's framebuffer. Sits beside `vga_adapter` in `veripong`, fed by the same plot signals.

## Interface

Parameters:

- `WIDTH`, default 320: frame width in pixels.
- `HEIGHT`, default 240: frame height in pixels.
- `X_W`, default 9: x coordinate width.
- `Y_W`, default 8: y coordinate width.
- `COLOUR_W`, default 3: colour width.
- `BACKGROUND`, default 3'b000: colour that counts as empty.

Ports:

- `clk`, in, 1: single clock; everything is `posedge`.
- `rst`, in, 1: synchronous, active-high reset.
- `plot`, in, 1: pixel write strobe.
- `X`, in, X_W: write x.
- `Y`, in, Y_W: write y.
- `color`, in, COLOUR_W: write colour.
- `clear`, in, 1: one-cycle pulse that starts a full-frame wipe.
- `q_valid`, in, 1: query request.
- `q_x`, in, X_W: query x.
- `q_y`, in, Y_W: query y.
- `q_ready`, out, 1: query accepted when `q_valid && q_ready`.
- `r_valid`, out, 1: one-cycle response strobe.
- `r_hit`, out, 1: 1 = occupied or outside the frame; held until the next response.
- `busy`, out, 1: wipe in progress.

## Operation

- Address = `y*WIDTH + x`, width `ADDR_W = $clog2(WIDTH*HEIGHT)` (17). Compute at full width with no truncation.
- In range means `x < WIDTH && y < HEIGHT`.
- **Write path**
  - Applies when `plot`, in range, and not `busy`.
  - Stores `mem[addr] <= (color != BACKGROUND)`.
  - Out-of-range plots are silently dropped.
  - Plots during a wipe are dropped.
- **FSM states**
  - CLEAR
    - Writes 0 to `sweep_addr` each cycle, starting at 0.
    - Moves to IDLE after address `WIDTH*HEIGHT-1`.
    - `busy=1`, `q_ready=0`.
  - IDLE
    - `q_ready=1`.
    - On accept, latch the query coordinates and go to READ.
  - READ
    - Issue the RAM read, or flag out-of-range.
    - Go to RSP.
  - RSP
    - `r_valid=1`; `r_hit` = RAM data, or 1 if out of range.
    - Return to IDLE.
- **Priority**
  - `rst` beats `clear`; `clear` beats everything else.
  - `clear` in any state goes to CLEAR with `sweep_addr=0`.
  - An in-flight query is abandoned: no `r_valid`.
  - `clear` during CLEAR restarts the sweep at 0.
- **Read/write collision:** a same-cycle plot write and RAM read at the same address returns the old value (read-before-write).
- The RAM has no reset. Reset enters CLEAR, so the shadow is always zero after reset.

## Timing

- **Reset values**
  - `q_ready=0`, `r_valid=0`, `r_hit=0`, `busy=1`.
  - State = CLEAR, `sweep_addr=0`.
- **Wipe:** `busy` stays high for exactly `WIDTH*HEIGHT` cycles (76800) after the reset/clear cycle. `q_ready` rises the following cycle.
- **Query latency:** accept at edge N, `r_valid` high in cycle N+2 for exactly one cycle.
- **Throughput:** one query per 3 cycles; `q_ready` is low in READ and RSP.
- **Write visibility:** a plot written at edge N is visible to a query accepted at edge N or later. It is not visible if the READ-cycle read coincides with the write edge.

## Structure

- Shared package `veripong_pkg`, containing:
  - `WIDTH`, `HEIGHT`, `X_W`, `Y_W`, `COLOUR_W`, `BACKGROUND`.
  - The state enum (`S_CLEAR`, `S_IDLE`, `S_READ`, `S_RSP`).
  - An address-compute function, shared with other plotters.
- Sub-module `shadow_ram`:
  - Simple dual-port, 1 bit x `WIDTH*HEIGHT`.
  - One synchronous write port, one synchronous read port, read-before-write.
  - Infers block RAM.
- The top holds the FSM, sweep counter, range checks and write muxing (sweep vs plot).

## Test plan

- Reset, then hold `rst=0` → `busy=1` for 76800 cycles, then `q_ready=1`. Query (5,5) → `r_valid` at +2, `r_hit=0`.
- Plot (10,20) with colour 3'b111, then query (10,20) → `r_hit=1`; query (11,20) → `r_hit=0`.
- Plot (10,20) with colour 3'b000 after the previous test → query (10,20) gives `r_hit=0`.
- Query (320,0) and (0,240) → `r_hit=1`. Plot (400,10) then query (400 mod 320=80,10) → `r_hit=0` (no aliasing).
- Same-cycle plot (7,7) colour 3'b001 and READ of (7,7) → `r_hit=0`; the next query of (7,7) → `r_hit=1`.
- Pulse `clear` the cycle after a query is accepted → no `r_valid` appears, `busy=1` for 76800 cycles, and all earlier hits read 0 afterwards. A plot during the wipe is dropped.
